// File: rtl/shiftreg_receiver_if.sv
`default_nettype none
// ============================================================================
// Module   : shiftreg_receiver_if
// Purpose  : Serial frame select/data inputs and latched frame outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface shiftreg_receiver_if #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16
) ();
    logic                  SELDYN;
    logic                  SELSTAT;
    logic                  SIGNAL_IN;
    logic [SIZESRDYN-1:0]  DYNLATCH;
    logic [SIZESRSTAT-1:0] STATLATCH;
    logic                  DYN_VALID;
    logic                  STAT_VALID;
    logic                  FRAME_ERR;
    logic                  BUSY;

    modport master (
        output SELDYN, SELSTAT, SIGNAL_IN,
        input  DYNLATCH, STATLATCH, DYN_VALID, STAT_VALID, FRAME_ERR, BUSY
    );

    modport slave (
        input  SELDYN, SELSTAT, SIGNAL_IN,
        output DYNLATCH, STATLATCH, DYN_VALID, STAT_VALID, FRAME_ERR, BUSY
    );
endinterface
`default_nettype wire

// File: rtl/shiftreg_receiver.sv
`default_nettype none
// ============================================================================
// Module   : shiftreg_receiver
// Purpose  : MSB-first serial receiver for dynamic and static frames.
// Revision : 1.0 - initial release
// ============================================================================
module shiftreg_receiver #(
    parameter int SIZESRSTAT = 88,
    parameter int SIZESRDYN  = 16,
    parameter int SIZECNT    = 7
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    shiftreg_receiver_if.slave bus
);
    localparam logic [1:0] c_idle    = 2'd0;
    localparam logic [1:0] c_rx_dyn  = 2'd1;
    localparam logic [1:0] c_rx_stat = 2'd2;

    localparam logic [SIZECNT-1:0] c_dyn_len  = SIZECNT'(SIZESRDYN);
    localparam logic [SIZECNT-1:0] c_stat_len = SIZECNT'(SIZESRSTAT);
    localparam logic [SIZECNT-1:0] c_cnt_one  = SIZECNT'(1);

    logic [1:0]            state_q, state_d;
    logic [SIZECNT-1:0]    cnt_q, cnt_d;
    // Only the first N-1 bits are stored; the final bit goes straight to the latch.
    logic [SIZESRDYN-2:0]  sr_dyn_q, sr_dyn_d;
    logic [SIZESRSTAT-2:0] sr_stat_q, sr_stat_d;
    logic [SIZESRDYN-1:0]  dyn_latch_q, dyn_latch_d;
    logic [SIZESRSTAT-1:0] stat_latch_q, stat_latch_d;
    logic                  dyn_valid_q, dyn_valid_d;
    logic                  stat_valid_q, stat_valid_d;
    logic                  frame_err_q, frame_err_d;

    logic                  w_dyn_bit, w_stat_bit, w_both;
    logic                  w_dyn_take, w_stat_take;
    logic                  w_dyn_last, w_stat_last, w_abort;
    logic [SIZECNT-1:0]    w_cnt_next;

    assign w_dyn_bit   = bus.SELDYN & ~bus.SELSTAT;
    assign w_stat_bit  = bus.SELSTAT & ~bus.SELDYN;
    assign w_both      = bus.SELDYN & bus.SELSTAT;
    assign w_cnt_next  = (state_q == c_idle) ? c_cnt_one : cnt_q + c_cnt_one;
    assign w_dyn_take  = w_dyn_bit & ((state_q == c_idle) | (state_q == c_rx_dyn));
    assign w_stat_take = w_stat_bit & ((state_q == c_idle) | (state_q == c_rx_stat));
    assign w_dyn_last  = w_dyn_take & (w_cnt_next == c_dyn_len);
    assign w_stat_last = w_stat_take & (w_cnt_next == c_stat_len);
    // Any select pattern other than "own select only" ends a frame in progress.
    assign w_abort     = w_both
                       | ((state_q == c_rx_dyn)  & ~w_dyn_bit)
                       | ((state_q == c_rx_stat) & ~w_stat_bit);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= c_idle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_idle: begin
                if (w_dyn_bit) begin
                    state_d = w_dyn_last ? c_idle : c_rx_dyn;
                end else if (w_stat_bit) begin
                    state_d = w_stat_last ? c_idle : c_rx_stat;
                end
            end
            c_rx_dyn:  state_d = (w_dyn_bit & ~w_dyn_last) ? c_rx_dyn : c_idle;
            c_rx_stat: state_d = (w_stat_bit & ~w_stat_last) ? c_rx_stat : c_idle;
            default:   state_d = c_idle;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        sr_dyn_d     = sr_dyn_q;
        sr_stat_d    = sr_stat_q;
        dyn_latch_d  = dyn_latch_q;
        stat_latch_d = stat_latch_q;
        dyn_valid_d  = 1'b0;
        stat_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        if (w_dyn_take) begin
            if (w_dyn_last) begin
                dyn_latch_d = {sr_dyn_q, bus.SIGNAL_IN};
                dyn_valid_d = 1'b1;
                sr_dyn_d    = '0;
                cnt_d       = '0;
            end else begin
                sr_dyn_d = {sr_dyn_q[SIZESRDYN-3:0], bus.SIGNAL_IN};
                cnt_d    = w_cnt_next;
            end
        end else if (w_stat_take) begin
            if (w_stat_last) begin
                stat_latch_d = {sr_stat_q, bus.SIGNAL_IN};
                stat_valid_d = 1'b1;
                sr_stat_d    = '0;
                cnt_d        = '0;
            end else begin
                sr_stat_d = {sr_stat_q[SIZESRSTAT-3:0], bus.SIGNAL_IN};
                cnt_d     = w_cnt_next;
            end
        end
        if (w_abort) begin
            cnt_d       = '0;
            sr_dyn_d    = '0;
            sr_stat_d   = '0;
            frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q        <= '0;
            sr_dyn_q     <= '0;
            sr_stat_q    <= '0;
            dyn_latch_q  <= '0;
            stat_latch_q <= '0;
            dyn_valid_q  <= 1'b0;
            stat_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            sr_dyn_q     <= sr_dyn_d;
            sr_stat_q    <= sr_stat_d;
            dyn_latch_q  <= dyn_latch_d;
            stat_latch_q <= stat_latch_d;
            dyn_valid_q  <= dyn_valid_d;
            stat_valid_q <= stat_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.DYNLATCH   = dyn_latch_q;
    assign bus.STATLATCH  = stat_latch_q;
    assign bus.DYN_VALID  = dyn_valid_q;
    assign bus.STAT_VALID = stat_valid_q;
    assign bus.FRAME_ERR  = frame_err_q;
    assign bus.BUSY       = (state_q != c_idle);
endmodule
`default_nettype wire
